// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mult_pkg
// Purpose : Shared types and constants for the registered array multiplier.
//           Holds the handshake FSM state enum, the settle counter width,
//           the default WIDTH/SETTLE values and the full-adder cell function
//           from which the array core is built.
// Revision: 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Settle counter width; it covers SETTLE values up to 15.
  localparam int CNT_W = 4;

  localparam int DEFAULT_WIDTH  = 4;
  localparam int DEFAULT_SETTLE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] f_adder(input logic x, input logic y, input logic cin);
    return {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
  endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/array_mult.sv
`default_nettype none
// ============================================================================
// Module  : array_mult
// Purpose : Purely combinational unsigned WIDTH x WIDTH array multiplier made
//           of rows of ripple full-adder cells.
// Ports   : a_r [WIDTH-1:0]    registered multiplicand
//           b_r [WIDTH-1:0]    registered multiplier
//           p   [2*WIDTH-1:0]  full-width product a_r * b_r
// Revision: 1.0 - initial release
// ============================================================================
module array_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]   a_r,
  input  logic [WIDTH-1:0]   b_r,
  output logic [2*WIDTH-1:0] p
);

  // acc holds the running partial sum aligned to the current row: bit 0 of
  // acc is product bit i after row i, so each row retires one product bit
  // and the remaining WIDTH bits feed the next row's adders.
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] pp;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [1:0]       fa;

  always_comb begin
    acc   = {1'b0, a_r & {WIDTH{b_r[0]}}};
    pp    = '0;
    sum   = '0;
    carry = 1'b0;
    fa    = '0;
    p     = '0;
    p[0]  = acc[0];
    for (int i = 1; i < WIDTH; i++) begin
      pp    = a_r & {WIDTH{b_r[i]}};
      carry = 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
        fa     = f_adder(acc[j+1], pp[j], carry);
        sum[j] = fa[0];
        carry  = fa[1];
      end
      acc  = {carry, sum};
      p[i] = acc[0];
    end
    p[2*WIDTH-1:WIDTH] = acc[WIDTH:1];
  end

endmodule : array_mult
`default_nettype wire

// File: rtl/mult_io_stage.sv
`default_nettype none
// ============================================================================
// Module  : mult_io_stage
// Purpose : Registered valid/ready wrapper around the combinational array
//           multiplier. Captures an operand pair, holds it for SETTLE cycles
//           while the array settles, then registers and presents the product
//           with downstream backpressure.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           in_valid / in_ready      operand handshake
//           a, b [WIDTH-1:0]         unsigned operands (sampled on accept)
//           out_valid / out_ready    product handshake
//           product [2*WIDTH-1:0]    registered a*b
//           busy                     high while the array settles (CALC)
//           zero                     product==0 flag (only with macro
//                                    MULT_ZERO_FLAG_EN defined)
// Config  : `define MULT_ZERO_FLAG_EN to add the registered zero flag.
// Revision: 1.0 - initial release
// ============================================================================
module mult_io_stage
  import mult_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
`ifdef MULT_ZERO_FLAG_EN
  ,
  output logic               zero
`endif
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  mult_state_t          state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 out_valid_q, out_valid_d;
`ifdef MULT_ZERO_FLAG_EN
  logic                 zero_q, zero_d;
`endif

  logic [2*WIDTH-1:0]   w_p;

  // The array only ever sees the registered operands.
  array_mult #(
    .WIDTH (WIDTH)
  ) u_array (
    .a_r (a_q),
    .b_r (b_q),
    .p   (w_p)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
`ifdef MULT_ZERO_FLAG_EN
    zero_d      = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cnt_d   = CNT_LOAD;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          product_d   = w_p;
          out_valid_d = 1'b1;
`ifdef MULT_ZERO_FLAG_EN
          // Derived from the operands so it does not wait on the array.
          zero_d      = (a_q == '0) || (b_q == '0);
`endif
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          // Same-edge handshake and accept skips the IDLE cycle.
          if (in_valid) begin
            a_d     = a;
            b_d     = b;
            cnt_d   = CNT_LOAD;
            state_d = CALC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef MULT_ZERO_FLAG_EN
      zero_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
`ifdef MULT_ZERO_FLAG_EN
      zero_q      <= zero_d;
`endif
    end
  end

  // Pure decode of state and out_ready; in_valid never reaches in_ready.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign busy      = (state_q == CALC);
  assign out_valid = out_valid_q;
  assign product   = product_q;
`ifdef MULT_ZERO_FLAG_EN
  assign zero      = zero_q;
`endif

endmodule : mult_io_stage
`default_nettype wire

// File: tb/tb_mult_io_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult_io_stage
// Purpose : Self-checking bench for mult_io_stage. A SETTLE=1 instance covers
//           reset, backpressure, back-to-back, reset priority, random and
//           exhaustive operands; a SETTLE=4 instance covers the settle count.
//           Expected products come from plain arithmetic on the accepted pair.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mult_io_stage;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic           in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] product;
  logic           in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [W-1:0]   a4, b4;
  logic [2*W-1:0] product4;
`ifdef MULT_ZERO_FLAG_EN
  logic           zero, zero4;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mult_io_stage #(.WIDTH(W), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
`ifdef MULT_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  mult_io_stage #(.WIDTH(W), .SETTLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .product(product4), .busy(busy4)
`ifdef MULT_ZERO_FLAG_EN
    , .zero(zero4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 2 time units
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned r;
    r = int'(x) * int'(y);
    return (2*W)'(r);
  endfunction

  // Present a pair and wait (bounded) for it to be accepted on an edge.
  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, output bit ok);
    ok       = 1'b0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    #1;
    for (int n = 0; n < 20; n++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    in_valid = 1'b0;
  endtask

  // Count cycles until out_valid, scrambling a/b each cycle meanwhile.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      a = W'($urandom);
      b = W'($urandom);
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (product !== '0) begin n_err++; $display("FAIL reset_product: got %h want 00", product); end
    n_cmp++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin n_err++; $display("FAIL reset_dut4: got ov=%b ir=%b want ov=0 ir=1", out_valid4, in_ready4); end
`ifdef MULT_ZERO_FLAG_EN
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b want 1", zero); end
`endif
  endtask

  task automatic test_basic();
    bit ok;
    int cyc;
    out_ready = 1'b1;
    accept(4'd15, 4'd15, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_accept: got no accept want accept"); end
    wait_valid(cyc);
    n_cmp++; if (cyc != 1) begin n_err++; $display("FAIL basic_latency: got %0d want 1", cyc); end
    n_cmp++; if (product !== ref_mul(4'd15, 4'd15)) begin n_err++; $display("FAIL basic_product: got %h want %h", product, ref_mul(4'd15, 4'd15)); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL basic_one_cycle: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    logic [2*W-1:0] e;
    e = ref_mul(4'd9, 4'd7);
    out_ready = 1'b0;
    accept(4'd9, 4'd7, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_accept: got no accept want accept"); end
    wait_valid(cyc);
    n_cmp++; if (product !== e) begin n_err++; $display("FAIL bp_product: got %h want %h", product, e); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || product !== e || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got ov=%b p=%h ir=%b want ov=1 p=%h ir=0", i, out_valid, product, in_ready, e);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_follows: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got ov=%b busy=%b ir=%b want 0 0 1", out_valid, busy, in_ready); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    out_ready = 1'b1;
    accept(4'd6, 4'd7, ok);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy: got %b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || product !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_calc: got ov=%b p=%h ir=%b busy=%b want 0 00 1 0", out_valid, product, in_ready, busy);
    end
    out_ready = 1'b0;
    accept(4'd2, 4'd3, ok);
    wait_valid(cyc);
    n_cmp++; if (product !== ref_mul(4'd2, 4'd3) || out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_after: got p=%h ov=%b want %h 1", product, out_valid, ref_mul(4'd2, 4'd3)); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || product !== '0) begin n_err++; $display("FAIL rstmid_done: got ov=%b p=%h want 0 00", out_valid, product); end
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xa [3];
    logic [W-1:0] xb [3];
    logic [2*W-1:0] e;
    xa = '{4'd3, 4'd12, 4'd0};
    xb = '{4'd5, 4'd11, 4'd13};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = xa[0];
    b = xb[0];
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_calc[%0d]: got busy=%b ov=%b want 1 0", i, busy, out_valid); end
      if (i < 2) begin
        a = xa[i+1];
        b = xb[i+1];
      end else begin
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
      end
      tick();
      e = ref_mul(xa[i], xb[i]);
      n_cmp++; if (out_valid !== 1'b1 || product !== e || in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_result[%0d]: got ov=%b p=%h ir=%b want 1 %h 1", i, out_valid, product, in_ready, e); end
`ifdef MULT_ZERO_FLAG_EN
      n_cmp++; if (zero !== (e == '0)) begin n_err++; $display("FAIL b2b_zero[%0d]: got %b want %b", i, zero, (e == '0)); end
`endif
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle: got ov=%b busy=%b ir=%b want 0 0 1", out_valid, busy, in_ready); end
  endtask

  task automatic test_settle4();
    int n;
    out_ready4 = 1'b1;
    in_valid4  = 1'b1;
    a4 = 4'd6;
    b4 = 4'd6;
    #1;
    n_cmp++; if (in_ready4 !== 1'b1) begin n_err++; $display("FAIL s4_in_ready: got %b want 1", in_ready4); end
    tick();
    in_valid4 = 1'b0;
    n = 0;
    while (busy4 && n < 20) begin
      a4 = W'($urandom);
      b4 = W'($urandom);
      tick();
      n++;
    end
    n_cmp++; if (n != 4) begin n_err++; $display("FAIL s4_busy_cycles: got %0d want 4", n); end
    n_cmp++; if (out_valid4 !== 1'b1 || product4 !== ref_mul(4'd6, 4'd6)) begin n_err++; $display("FAIL s4_result: got ov=%b p=%h want 1 %h", out_valid4, product4, ref_mul(4'd6, 4'd6)); end
    tick();
    n_cmp++; if (out_valid4 !== 1'b0) begin n_err++; $display("FAIL s4_release: got %b want 0", out_valid4); end
  endtask

  task automatic test_random();
    bit ok;
    int cyc;
    int hold;
    logic [W-1:0] ra, rb;
    logic [2*W-1:0] e;
    for (int t = 0; t < 40; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      e  = ref_mul(ra, rb);
      out_ready = 1'b0;
      accept(ra, rb, ok);
      wait_valid(cyc);
      n_cmp++; if (!ok || cyc != 1 || product !== e) begin n_err++; $display("FAIL rand[%0d]: got ok=%b lat=%0d p=%h want 1 1 %h", t, ok, cyc, product, e); end
      hold = int'($urandom_range(0, 3));
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
        tick();
      end
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || product !== e) begin n_err++; $display("FAIL rand_hold[%0d]: got ov=%b p=%h want 1 %h", t, out_valid, product, e); end
      out_ready = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rand_release[%0d]: got %b want 0", t, out_valid); end
    end
  endtask

  task automatic test_sweep();
    bit ok;
    int cyc;
    logic [2*W-1:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < (1 << W); i++) begin
      for (int j = 0; j < (1 << W); j++) begin
        e = ref_mul(W'(i), W'(j));
        accept(W'(i), W'(j), ok);
        wait_valid(cyc);
        n_cmp++;
        if (!ok || out_valid !== 1'b1 || product !== e) begin
          n_err++;
          $display("FAIL sweep %0d*%0d: got ok=%b ov=%b p=%h want 1 1 %h", i, j, ok, out_valid, product, e);
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_settle4();
    test_random();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mult_io_stage
`default_nettype wire
